solar_track_ctrl: RTL and testbench

SOLAR_TRACK_CTRL -- requirements
Module: solar_track_ctrl

---
 rtl/solar_track_ctrl.sv | 156 +++++++++++++++
 tb/tb_solar_track_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/solar_track_ctrl.sv
// Per-axis sun-tracking motor controller: evaluates sensor balance (auto) or angle error (manual)
// and issues bounded drive pulses followed by a settle period. Optional hysteresis via TRACK_HYST_EN.
module solar_track_ctrl #(
    parameter int unsigned W          = 16,
    parameter int unsigned N_AXES     = 2,
    parameter int unsigned DEADBAND   = 4,
    parameter int unsigned DRIVE_CYC  = 1000,
    parameter int unsigned SETTLE_CYC = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sma,
    input  logic                  sample_valid,
    input  logic [N_AXES*W-1:0]   sens_a,
    input  logic [N_AXES*W-1:0]   sens_b,
    input  logic [N_AXES*W-1:0]   ang_manual,
    input  logic [N_AXES*W-1:0]   ang_actual,
    output logic [N_AXES-1:0]     drv_pos,
    output logic [N_AXES-1:0]     drv_neg,
    output logic [N_AXES-1:0]     busy,
    output logic [N_AXES-1:0]     at_target
);

    localparam int unsigned CMAX = (DRIVE_CYC > SETTLE_CYC) ? DRIVE_CYC : SETTLE_CYC;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned EW   = W + 2;

    localparam logic signed [EW-1:0] DB_NARROW = EW'(DEADBAND);
`ifdef TRACK_HYST_EN
    localparam logic signed [EW-1:0] DB_WIDE   = EW'(2 * DEADBAND);
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EVAL      = 3'd1,
        S_DRIVE_POS = 3'd2,
        S_DRIVE_NEG = 3'd3,
        S_SETTLE    = 3'd4
    } state_t;

    for (genvar k = 0; k < N_AXES; k++) begin : g_axis
        state_t              state_q, state_d;
        logic [CW-1:0]       cnt_q, cnt_d;
        logic [W-1:0]        opa_q, opa_d, opb_q, opb_d;
        logic                sma_q, sma_d;
        logic                pos_q, pos_d, neg_q, neg_d;
        logic                busy_q, busy_d, tgt_q, tgt_d;
        logic signed [EW-1:0] err_c, thr_c;

        // Zero-extended subtraction keeps the full signed range of a W-bit difference.
        assign err_c = $signed({2'b00, opa_q}) - $signed({2'b00, opb_q});

`ifdef TRACK_HYST_EN
        assign thr_c = tgt_q ? DB_WIDE : DB_NARROW;
`else
        assign thr_c = DB_NARROW;
`endif

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                opa_q   <= '0;
                opb_q   <= '0;
                sma_q   <= 1'b0;
                pos_q   <= 1'b0;
                neg_q   <= 1'b0;
                busy_q  <= 1'b0;
                tgt_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                opa_q   <= opa_d;
                opb_q   <= opb_d;
                sma_q   <= sma_d;
                pos_q   <= pos_d;
                neg_q   <= neg_d;
                busy_q  <= busy_d;
                tgt_q   <= tgt_d;
            end
        end

        // Next-state logic; drive/busy outputs are registered from the next state.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            opa_d   = opa_q;
            opb_d   = opb_q;
            sma_d   = sma_q;
            pos_d   = 1'b0;
            neg_d   = 1'b0;
            busy_d  = 1'b1;
            tgt_d   = tgt_q;
            case (state_q)
                S_IDLE: begin
                    busy_d = 1'b0;
                    cnt_d  = '0;
                    if (sample_valid) begin
                        state_d = S_EVAL;
                        busy_d  = 1'b1;
                        sma_d   = sma;
                        opa_d   = sma ? sens_a[k*W +: W] : ang_manual[k*W +: W];
                        opb_d   = sma ? sens_b[k*W +: W] : ang_actual[k*W +: W];
                    end
                end
                S_EVAL: begin
                    if (err_c > thr_c) begin
                        state_d = S_DRIVE_POS;
                        cnt_d   = CW'(DRIVE_CYC - 1);
                        pos_d   = 1'b1;
                        tgt_d   = 1'b0;
                    end else if (err_c < -thr_c) begin
                        state_d = S_DRIVE_NEG;
                        cnt_d   = CW'(DRIVE_CYC - 1);
                        neg_d   = 1'b1;
                        tgt_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        tgt_d   = 1'b1;
                    end
                end
                S_DRIVE_POS, S_DRIVE_NEG: begin
                    // A live mode change aborts the pulse into a quiet period.
                    if ((sma != sma_q) || (cnt_q == '0)) begin
                        state_d = S_SETTLE;
                        cnt_d   = CW'(SETTLE_CYC - 1);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                        pos_d = (state_q == S_DRIVE_POS);
                        neg_d = (state_q == S_DRIVE_NEG);
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end

        assign drv_pos[k]   = pos_q;
        assign drv_neg[k]   = neg_q;
        assign busy[k]      = busy_q;
        assign at_target[k] = tgt_q;
    end

endmodule

// File: tb/tb_solar_track_ctrl.sv
// Directed self-checking bench for solar_track_ctrl (W=16, 2 axes, DEADBAND=4, DRIVE=8, SETTLE=4).
module tb_solar_track_ctrl;

    localparam int unsigned W = 16;
    localparam int unsigned N = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           sma;
    logic           sample_valid;
    logic [N*W-1:0] sens_a, sens_b, ang_manual, ang_actual;
    logic [N-1:0]   drv_pos, drv_neg, busy, at_target;

    int checks = 0;
    int errors = 0;

    solar_track_ctrl #(
        .W(W), .N_AXES(N), .DEADBAND(4), .DRIVE_CYC(8), .SETTLE_CYC(4)
    ) dut (
        .clk(clk), .rst(rst), .sma(sma), .sample_valid(sample_valid),
        .sens_a(sens_a), .sens_b(sens_b), .ang_manual(ang_manual), .ang_actual(ang_actual),
        .drv_pos(drv_pos), .drv_neg(drv_neg), .busy(busy), .at_target(at_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 (one edge after the strobe cycle).
    task automatic sv_pulse();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic set_sens(input int a0, input int b0, input int a1, input int b1);
        sens_a = {W'(a1), W'(a0)};
        sens_b = {W'(b1), W'(b0)};
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 2'b00 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
        tick();
    endtask

    function automatic logic in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    initial begin
        rst = 1'b1; sma = 1'b1; sample_valid = 1'b0;
        set_sens(0, 0, 0, 0);
        ang_manual = '0; ang_actual = '0;
        #2 rst = 1'b0;
        #1;
        chk("reset_outputs", 32'({drv_pos, drv_neg, busy, at_target}), 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("post_reset_idle", 32'({drv_pos, drv_neg, busy, at_target}), 32'd0);

        // Auto mode: axis0 drives positive, axis1 balanced.
        sma = 1'b1;
        set_sens(40, 5, 30, 30);
        sv_pulse();
        for (int c = 1; c <= 15; c++) begin
            chk($sformatf("auto_pos_c%0d", c), 32'({drv_pos, drv_neg, busy, at_target}),
                32'({1'b0, in_rng(c, 2, 9), 2'b00, c == 1, in_rng(c, 1, 13), c >= 2, 1'b0}));
            tick();
        end

        // Manual mode: axis1 drives negative, axis0 on target.
        sma = 1'b0;
        ang_manual = {W'(5), W'(100)};
        ang_actual = {W'(45), W'(100)};
        sv_pulse();
        for (int c = 1; c <= 14; c++) begin
            chk($sformatf("manual_neg_c%0d", c), 32'({drv_pos, drv_neg, busy, at_target}),
                32'({2'b00, in_rng(c, 2, 9), 1'b0, in_rng(c, 1, 13), c == 1, c < 2, c >= 2}));
            tick();
        end

        // Deadband edges: +4 on axis0 stays, +5 on axis1 drives.
        sma = 1'b1;
        set_sens(14, 10, 15, 10);
        sv_pulse(); tick();
        chk("edge_p4_p5_pos", 32'(drv_pos), 32'b10);
        chk("edge_p4_p5_neg", 32'(drv_neg), 32'b00);
        chk("edge_p4_p5_tgt", 32'(at_target), 32'b01);
        wait_idle("edge_p5_idle");

        // Full-scale negative on axis0 and -5 on axis1.
        set_sens(0, 65535, 10, 15);
        sv_pulse(); tick();
        chk("edge_neg_pos", 32'(drv_pos), 32'b00);
        chk("edge_neg_neg", 32'(drv_neg), 32'b11);
        chk("edge_neg_tgt", 32'(at_target), 32'b00);
        wait_idle("edge_neg_idle");

        // Mode toggle in the 4th drive cycle aborts; a strobe mid-drive is ignored by axis0.
        set_sens(40, 5, 30, 30);
        sv_pulse();
        for (int c = 1; c <= 11; c++) begin
            chk($sformatf("abort_c%0d", c), 32'({drv_pos, drv_neg, busy, at_target}),
                32'({1'b0, in_rng(c, 2, 5), 2'b00, (c == 1) || (c == 4), in_rng(c, 1, 9), c >= 2, 1'b0}));
            if (c == 3) begin
                set_sens(5, 40, 30, 30);
                sample_valid = 1'b1;
            end
            if (c == 4) sample_valid = 1'b0;
            if (c == 5) sma = 1'b0;
            tick();
        end
        sma = 1'b1;
        wait_idle("abort_idle");

        // Hysteresis: put axis0 on target, then try +6 and +9.
        set_sens(20, 20, 20, 20);
        sv_pulse(); tick();
        chk("hyst_ontarget", 32'(at_target), 32'b11);
        wait_idle("hyst_ontarget_idle");
        set_sens(26, 20, 20, 20);
        sv_pulse(); tick();
`ifdef TRACK_HYST_EN
        chk("hyst_p6_pos", 32'(drv_pos), 32'b00);
        chk("hyst_p6_tgt", 32'(at_target), 32'b11);
`else
        chk("hyst_p6_pos", 32'(drv_pos), 32'b01);
        chk("hyst_p6_tgt", 32'(at_target), 32'b10);
`endif
        wait_idle("hyst_p6_idle");
        set_sens(29, 20, 20, 20);
        sv_pulse(); tick();
        chk("hyst_p9_pos", 32'(drv_pos), 32'b01);
        wait_idle("hyst_p9_idle");

        // Asynchronous reset mid-drive.
        set_sens(40, 5, 30, 30);
        sv_pulse(); tick(); tick(); tick();
        chk("pre_rst_drive", 32'(drv_pos), 32'b01);
        #2 rst = 1'b0;
        #1;
        chk("rst_async", 32'({drv_pos, drv_neg, busy, at_target}), 32'd0);
        tick();
        chk("rst_held", 32'({drv_pos, drv_neg, busy, at_target}), 32'd0);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("rst_release_c%0d", c), 32'({drv_pos, drv_neg, busy, at_target}), 32'd0);
        end

        // Strobe in the same cycle as reset release is accepted.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        sv_pulse();
        chk("rel_sv_busy", 32'(busy), 32'b11);
        tick();
        chk("rel_sv_drive", 32'({drv_pos, at_target}), 32'b01_10);
        wait_idle("rel_sv_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
